// File: rtl/muldiv_seq_if.sv
// Issue / HI-LO access bundle between the EX stage and the multi-cycle mul/div sequencer.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             hilo_rd;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;

    modport master (
        output start, op, opA, opB, hilo_rd, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, div_by_zero, stall
    );

    modport slave (
        input  start, op, opA, opB, hilo_rd, hi_we, lo_we, wdata,
        output hi, lo, busy, done, div_by_zero, stall
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shift-add multiply or
// restoring divide on operand magnitudes over WIDTH cycles, then one sign-fix cycle.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_out_q, dbz_out_d;

    // Operand magnitudes; op[0]==0 selects the signed variants.
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.opA[WIDTH-1];
    assign b_neg     = is_signed & bus.opB[WIDTH-1];
    assign a_mag     = a_neg ? -bus.opA : bus.opA;
    assign b_mag     = b_neg ? -bus.opB : bus.opB;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_iter;
    logic [WIDTH-1:0]     quot, rem;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, dvs_q};
    assign div_diff = div_sh[WIDTH-1:0] - dvs_q;
    assign acc_iter = !op_q[1] ? {mul_sum, acc_q[WIDTH-1:1]} :
                      div_ge   ? {div_diff, acc_q[WIDTH-2:0], 1'b1} :
                                 {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    assign quot     = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == LAST_CNT) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.stall = bus.busy & (bus.start | bus.hilo_rd | bus.hi_we | bus.lo_we);
    end

    always_comb begin
        // NOTE: every _d defaults to its hold value first, so no branch can infer a latch.
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        dvs_d     = dvs_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    cnt_d     = '0;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = bus.op[1] & ~|bus.opB;
                    dvs_d     = bus.op[1] ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            CALC: begin
                acc_d = acc_iter;
                if (cnt_q != LAST_CNT) cnt_d = cnt_q + CNT_W'(1);
            end
            FIX: begin
                // A zero divisor leaves |opA| as remainder, so the sign fix restores opA.
                if (op_q[1]) begin
                    lo_d = dbz_q ? '1 : (neg_res_q ? -quot : quot);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                end
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            dvs_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            dvs_q     <= dvs_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboarded random + directed bench for muldiv_seq against a plain-arithmetic model.
module tb_muldiv_seq;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: full-width signed/unsigned arithmetic, SV / and % truncate toward zero.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, p;
        logic [63:0] up;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dbz = 1'b0;
        case (op)
            2'd0: begin
                p    = sa * sb;
                e.hi = 32'(p >>> 32);
                e.lo = 32'(p);
            end
            2'd1: begin
                up   = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            2'd2: begin
                if (b == 0) begin
                    e.dbz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else begin
                    e.lo = 32'(sa / sb);
                    e.hi = 32'(sa % sb);
                end
            end
            default: begin
                if (b == 0) begin
                    e.dbz = 1'b1; e.lo = 32'hFFFF_FFFF; e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.done) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1, expected no pending op at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("result_hi", bus.hi, e.hi);
                check("result_lo", bus.lo, e.lo);
                check("div_by_zero", bus.div_by_zero, e.dbz);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        if (expect_done) sb_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at a negedge with busy high; returns at the negedge after the done cycle.
    task automatic wait_done(input bit check_len);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: got busy after %0d cycles, expected idle", n);
        end
        if (check_len) check("busy_cycles", n, 33);
        check("done_pulse", bus.done, 1);
        @(negedge clk);
        check("done_width", bus.done, 0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b, 1'b1);
        wait_done(1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] prev_hi, prev_lo, a, b;
        logic [1:0]  op;
        int          n;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.opA     = '0;
        bus.opB     = '0;
        bus.hilo_rd = 1'b0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_dbz", bus.div_by_zero, 0);
        check("reset_stall", bus.stall, 0);
        reset = 1'b0;

        // Directed cases from the known corner list.
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd100, 32'd0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000);

        // MT writes in IDLE land at the next edge.
        @(negedge clk);
        bus.lo_we = 1'b1; bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mtlo_idle", bus.lo, 32'h0BAD_F00D);

        // start wins over a coincident MTHI.
        prev_hi = bus.hi;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.opA = 32'd1000; bus.opB = 32'd7;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        sb_q.push_back(model(2'd3, 32'd1000, 32'd7));
        @(negedge clk);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        check("mt_dropped_on_start", bus.hi, prev_hi);
        wait_done(1'b1);

        // Randomized operations with some zero divisors and extreme operands.
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b);
        end

        // Hazards while busy: hilo_rd, then a held second start.
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        prev_hi = bus.hi;
        prev_lo = bus.lo;
        repeat (4) @(negedge clk);
        bus.hilo_rd = 1'b1;
        #1 check("stall_hilo_rd", bus.stall, 1);
        @(negedge clk);
        bus.hilo_rd = 1'b0;
        #1 check("stall_no_request", bus.stall, 0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.opA = 32'hFFFF_0000; bus.opB = 32'd3;
        sb_q.push_back(model(2'd3, 32'hFFFF_0000, 32'd3));
        n = 0;
        while (bus.busy && n < 200) begin
            #1;
            check("stall_start_busy", bus.stall, 1);
            check("hi_held_busy", bus.hi, prev_hi);
            check("lo_held_busy", bus.lo, prev_lo);
            @(negedge clk);
            n++;
        end
        #1;
        check("stall_released", bus.stall, 0);
        check("first_done", bus.done, 1);
        @(negedge clk);
        bus.start = 1'b0;
        check("second_accepted", bus.busy, 1);
        wait_done(1'b1);

        // Reset mid-operation aborts with no done pulse.
        issue(2'd3, 32'd123456, 32'd789, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_after_abort", bus.hi, 32'h0000_1234);
        check("lo_after_abort", bus.lo, 0);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage. It runs alongside the single-cycle ALU and owns the HI/LO registers. It iterates a shift-add multiplier or a restoring divider over WIDTH cycles. Its stall output holds IF/ID/EX while a dependent HI/LO access or a new mul/div issue collides with an operation in flight.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  issue request from EX (decoded mul/div func)
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opA  in  WIDTH  rs operand (multiplicand / dividend)
opB  in  WIDTH  rt operand (multiplier / divisor)
hilo_rd  in  1  MFHI/MFLO in EX this cycle
hi_we  in  1  MTHI in EX; writes wdata to HI
lo_we  in  1  MTLO in EX; writes wdata to LO
wdata  in  WIDTH  MTHI/MTLO data
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
busy  out  1  operation in flight (state != IDLE)
done  out  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  out  1  pulses with done when DIV/DIVU had opB==0
stall  out  1  combinational: busy & (start | hilo_rd | hi_we | lo_we)

Behaviour:
- Reset values (async, immediate): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX.
- IDLE + start: latch op, |opA|, |opB| (magnitudes only for signed ops), sign flags, counter=0; go to CALC.
- IDLE + hi_we/lo_we, no start: write wdata to HI/LO at that edge.
- start together with hi_we/lo_we in IDLE: start takes priority; the MT write is dropped (decoder never issues both).
- CALC: one iteration per cycle for WIDTH cycles.
  - Multiply: 2*WIDTH-bit shift-add, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - When counter==WIDTH-1, go to FIX; otherwise increment counter.
- FIX (one cycle): apply sign correction and write HI/LO at the exiting edge; go to IDLE. done=1 (and div_by_zero if applicable) for exactly the next cycle.
- Latency: start sampled at edge E0; CALC covers E1..E32; HI/LO update and busy falls at E33 (WIDTH=32). done is high in cycle E33..E34.
- Signed multiply: negate the 2*WIDTH product if signs differ. Unsigned: no correction.
- Signed divide:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (opB==0): still takes the full latency. Result is lo=all ones, hi=opA as latched (signed ops: original opA). div_by_zero pulses with done.
- Placement: lo = product low word / quotient; hi = product high word / remainder.
- While busy:
  - start, hi_we and lo_we are ignored by this block.
  - stall is asserted so the pipeline holds the instruction until IDLE.
  - In the first IDLE cycle the held request proceeds, with stall=0.
- hilo_rd while busy asserts stall. hi/lo outputs keep their previous values until FIX completes.
- Reset mid-operation aborts immediately: HI/LO=0, no done pulse.
- No back-to-back issue: a start on the cycle after FIX is accepted normally, since state is IDLE.

Test Plan:
- MULT opA=0xFFFFFFFD (-3), opB=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done single pulse; busy high for exactly 33 cycles.
- MULTU opA=opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; same MULT operands give hi=0, lo=1.
- DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU opA=100, opB=0 -> lo=0xFFFFFFFF, hi=0x64, div_by_zero=1 together with done.
- start MULT, assert hilo_rd at cycle 5 and a second start at cycle 10 -> stall=1 whenever either is high while busy; second op ignored until IDLE; HI/LO unchanged until the first done.
- start DIVU, assert reset at cycle 10 for 1 cycle -> busy=0, hi=lo=0 immediately, no done; a subsequent MTHI 0x1234 gives hi=0x1234 next cycle.
